// File: rtl/ifu_fetch.sv
// ifu_fetch: PC generation, single-outstanding imem fetch, pre-decode, IBUF.
// Optional macro IFU_PERF_CNT_EN adds fetch/drop performance counters.
`ifndef OPCODE_JAL
`define OPCODE_JAL 7'b1101111
`endif
`ifndef OPCODE_BREACH
`define OPCODE_BREACH 7'b1100011
`endif

module ifu_fetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              IBUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [XLEN-1:0] bpu_pc,
  output logic [31:0]     bpu_imm,
  output logic [6:0]      bpu_opcode,
  input  logic [XLEN-1:0] bpu_pc_pred,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);

  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t state, state_nx;

  logic [XLEN-1:0] pc, pc_nx, pc_plus4;
  logic [31:0]     imm;
  logic [6:0]      opc;
  logic            pred_taken;
  logic            accept, push, pop, drop;

  logic [XLEN-1:0] q_pc   [IBUF_DEPTH];
  logic [31:0]     q_ins  [IBUF_DEPTH];
  logic            q_tk   [IBUF_DEPTH];
  logic [XLEN-1:0] q_pp   [IBUF_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic unused_ok;
  assign unused_ok = ^redirect_pc[1:0];

  assign opc      = imem_rsp_data[6:0];
  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    imm = '0;
    unique case (1'b1)
      (opc == `OPCODE_JAL):
        imm = {{11{imem_rsp_data[31]}}, imem_rsp_data[31],
               imem_rsp_data[19:12], imem_rsp_data[20],
               imem_rsp_data[30:21], 1'b0};
      (opc == `OPCODE_BREACH):
        imm = {{19{imem_rsp_data[31]}}, imem_rsp_data[31],
               imem_rsp_data[7], imem_rsp_data[30:25],
               imem_rsp_data[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

  assign bpu_pc     = pc;
  assign bpu_imm    = imm;
  assign bpu_opcode = opc;
  assign pred_taken = (bpu_pc_pred != pc_plus4);

  assign imem_req_valid = !rst && (state == S_REQ)
                          && (count < CW'(IBUF_DEPTH));
  assign imem_req_addr  = pc;
  assign accept = imem_req_valid && imem_req_ready;

  assign if_valid = (count != '0);
  assign pop  = if_valid && if_ready;
  assign push = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  // A response is thrown away when stale or killed by a same-cycle redirect
  assign drop = imem_rsp_valid && ((state == S_DROP)
                || ((state == S_WAIT) && redirect_valid));

  assign if_pc         = q_pc[rd_ptr];
  assign if_instr      = q_ins[rd_ptr];
  assign if_pred_taken = q_tk[rd_ptr];
  assign if_pred_pc    = q_pp[rd_ptr];

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    unique case (state)
      S_REQ:  if (accept) state_nx = S_WAIT;
      S_WAIT: if (imem_rsp_valid) begin
        state_nx = S_REQ;
        pc_nx    = {bpu_pc_pred[XLEN-1:2], 2'b00};
      end
      S_DROP: if (imem_rsp_valid) state_nx = S_REQ;
      default: state_nx = S_REQ;
    endcase
    if (redirect_valid) begin
      pc_nx = {redirect_pc[XLEN-1:2], 2'b00};
      unique case (state)
        S_REQ:   state_nx = accept ? S_DROP : S_REQ;
        S_WAIT:  state_nx = imem_rsp_valid ? S_REQ : S_DROP;
        S_DROP:  state_nx = imem_rsp_valid ? S_REQ : S_DROP;
        default: state_nx = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= {RESET_PC[XLEN-1:2], 2'b00};
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        q_pc[i]  <= '0;
        q_ins[i] <= '0;
        q_tk[i]  <= 1'b0;
        q_pp[i]  <= '0;
      end
    end else if (redirect_valid) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]  <= pc;
        q_ins[wr_ptr] <= imem_rsp_data;
        q_tk[wr_ptr]  <= pred_taken;
        q_pp[wr_ptr]  <= bpu_pc_pred;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (drop) perf_drop_cnt  <= perf_drop_cnt + 32'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed checks of fetch sequencing, pre-decode,
// backpressure, redirects and mid-run reset for ifu_fetch.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] bpu_pc, bpu_imm, bpu_pc_pred;
  logic [6:0]  bpu_opcode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr, if_pred_pc;
  logic        if_pred_taken;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif

  localparam logic [31:0] JAL_W = 32'hFF9F_F06F;
  localparam logic [31:0] BEQ_W = 32'h0000_0863;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  always #5 clk = ~clk;

  // Static predictor: JAL taken to pc+imm, everything else falls through
  assign bpu_pc_pred = (bpu_opcode == 7'h6F) ? bpu_pc + bpu_imm
                                             : bpu_pc + 32'd4;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .bpu_pc         (bpu_pc),
    .bpu_imm        (bpu_imm),
    .bpu_opcode     (bpu_opcode),
    .bpu_pc_pred    (bpu_pc_pred),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_pred_taken  (if_pred_taken),
    .if_pred_pc     (if_pred_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          lat = 1;
  int          pend = 0;
  logic [31:0] pend_addr = '0;
  bit          jal_used = 1'b0;
  bit          drdy = 1'b0;
  bit          acc, popd;
  logic [31:0] imm_10 = '0;
  logic [31:0] imm_20 = '0;
  logic [31:0] acc_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_pp_q[$];
  logic        pop_tk_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h10 && !jal_used) return JAL_W;
    if (a == 32'h20) return BEQ_W;
    return NOP_W;
  endfunction

  task automatic clear_logs();
    acc_q.delete();
    pop_pc_q.delete();
    pop_pp_q.delete();
    pop_tk_q.delete();
  endtask

  // One clock cycle: drive inputs at negedge, sample 1ns later
  task automatic cyc(input bit rv, input logic [31:0] rpc);
    @(negedge clk);
    if (pend == 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(pend_addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    if (pend > 0) pend--;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = drdy;
    #1;
    if (imem_rsp_valid) begin
      if (imem_rsp_data == JAL_W) begin
        imm_10   = bpu_imm;
        jal_used = 1'b1;
      end
      if (imem_rsp_data == BEQ_W) imm_20 = bpu_imm;
    end
    acc = imem_req_valid && imem_req_ready;
    if (acc) begin
      acc_q.push_back(imem_req_addr);
      pend      = lat;
      pend_addr = imem_req_addr;
    end
    popd = if_valid && if_ready;
    if (popd) begin
      pop_pc_q.push_back(if_pc);
      pop_pp_q.push_back(if_pred_pc);
      pop_tk_q.push_back(if_pred_taken);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp1 [13];
    logic [31:0] exp3 [4];
    bit found;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] f0;
`endif
    exp1 = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h08, 32'h0C,
             32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24};
    exp3 = '{32'h24, 32'h28, 32'h2C, 32'h30};
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_bpu_pc", bpu_pc, 0);
`ifdef IFU_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 0);
    chk("rst_perf_drop", perf_drop_cnt, 0);
`endif
    imem_req_ready = 1'b1;
    drdy = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;

    // Sequential fetch, JAL at 0x10 (taken once), BEQ at 0x20
    cyc(0, 0);
    chk("first_req_valid", acc, 1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    for (int i = 0; i < 300 && acc_q.size() < 13; i++) cyc(0, 0);
    chk("p1_acc_count", acc_q.size(), 13);
    if (acc_q.size() >= 13)
      for (int i = 0; i < 13; i++)
        chk($sformatf("p1_addr%0d", i), acc_q[i], exp1[i]);
    chk("p1_pop_count", pop_pc_q.size(), 12);
    if (pop_pc_q.size() >= 12) begin
      chk("p1_pop0_pc", pop_pc_q[0], 32'h0);
      chk("p1_pop0_tk", pop_tk_q[0], 0);
      chk("p1_pop0_pp", pop_pp_q[0], 32'h4);
      chk("p1_pop1_pc", pop_pc_q[1], 32'h4);
      chk("p1_pop1_pp", pop_pp_q[1], 32'h8);
      chk("p1_jal_pc", pop_pc_q[4], 32'h10);
      chk("p1_jal_tk", pop_tk_q[4], 1);
      chk("p1_jal_pp", pop_pp_q[4], 32'h08);
      chk("p1_beq_pc", pop_pc_q[11], 32'h20);
      chk("p1_beq_tk", pop_tk_q[11], 0);
      chk("p1_beq_pp", pop_pp_q[11], 32'h24);
    end
    chk("jal_imm", imm_10, 32'hFFFF_FFF8);
    chk("beq_imm", imm_20, 32'h10);

    // Backpressure: two entries buffered, then requests stop
    clear_logs();
    drdy = 1'b0;
    repeat (12) cyc(0, 0);
    chk("p2_acc_count", acc_q.size(), 1);
    if (acc_q.size() >= 1) chk("p2_addr", acc_q[0], 32'h28);
    chk("p2_req_stall", imem_req_valid, 0);
    chk("p2_if_valid", if_valid, 1);
    chk("p2_head_pc", if_pc, 32'h24);

    // Release: buffered and new PCs come out in order
    clear_logs();
    drdy = 1'b1;
    for (int i = 0; i < 60 && pop_pc_q.size() < 4; i++) cyc(0, 0);
    chk("p3_pop_count", pop_pc_q.size() >= 4, 1);
    if (pop_pc_q.size() >= 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("p3_pop%0d", i), pop_pc_q[i], exp3[i]);

    // Redirect while waiting on a slow response
    lat = 2;
    drdy = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(0, 0);
      found = acc && if_valid;
    end
    chk("p4_found_wait", found, 1);
    cyc(1, 32'h103);
    chk("p4_pre_if_valid", if_valid, 1);
    lat = 1;
    cyc(0, 0);
    chk("p4_flush", if_valid, 0);
    cyc(0, 0);
    chk("p4_no_push", if_valid, 0);
    chk("p4_req_valid", imem_req_valid, 1);
    chk("p4_req_addr", imem_req_addr, 32'h100);
`ifdef IFU_PERF_CNT_EN
    chk("p4_drop_cnt", perf_drop_cnt, 1);
`endif

    // Redirect coinciding with the response for 0x100
    drdy = 1'b1;
    cyc(1, 32'h200);
    // Redirect coinciding with acceptance of 0x200
    cyc(1, 32'h300);
    chk("p5_no_push", if_valid, 0);
    chk("p5_req_valid", imem_req_valid, 1);
    chk("p5_req_addr", imem_req_addr, 32'h200);
`ifdef IFU_PERF_CNT_EN
    chk("p5_drop_cnt", perf_drop_cnt, 2);
    f0 = perf_fetch_cnt;
`endif
    cyc(0, 0);
    chk("p6_no_push", if_valid, 0);
    cyc(0, 0);
    chk("p6_req_valid", imem_req_valid, 1);
    chk("p6_req_addr", imem_req_addr, 32'h300);
`ifdef IFU_PERF_CNT_EN
    chk("p6_drop_cnt", perf_drop_cnt, 3);
`endif
    clear_logs();
    for (int i = 0; i < 20 && pop_pc_q.size() < 1; i++) cyc(0, 0);
    chk("p6_pop_seen", pop_pc_q.size() >= 1, 1);
    if (pop_pc_q.size() >= 1) begin
      chk("p6_pop_pc", pop_pc_q[0], 32'h300);
      chk("p6_pop_pp", pop_pp_q[0], 32'h304);
      chk("p6_pop_tk", pop_tk_q[0], 0);
    end
`ifdef IFU_PERF_CNT_EN
    chk("p6_fetch_cnt", perf_fetch_cnt, f0 + 32'd1);
`endif

    // Reset in the middle of traffic
    repeat (3) cyc(0, 0);
    @(negedge clk);
    rst = 1'b1;
    pend = 0;
    imem_rsp_valid = 1'b0;
    #1;
    chk("mid_rst_req_valid", imem_req_valid, 0);
    chk("mid_rst_if_valid", if_valid, 0);
    chk("mid_rst_addr", imem_req_addr, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    clear_logs();
    cyc(0, 0);
    chk("post_rst_acc", acc_q.size(), 1);
    if (acc_q.size() >= 1) chk("post_rst_addr", acc_q[0], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
